// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: synchronised, glitch-filtered START/STOP detection plus byte/ACK capture.
// Optional SCL-low bus timeout is built only when I2C_TIMEOUT_EN is defined. DATA_W must be at least 2.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              start_det,
  output logic              stop_det,
  output logic              bus_busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              ack_bit,
  output logic              ack_valid,
  output logic              timeout
);

  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic [1:0]             w_line_s;
  logic [1:0]             r_line_f;
  logic [1:0]             r_line_p;
  logic [FCW-1:0]         r_fcnt [2];

  logic w_scl_f, w_sda_f, w_scl_p, w_sda_p;
  logic w_start, w_stop, w_rise, w_to_evt;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-2:0] r_shift, w_shift_nxt;
  logic [DATA_W-1:0] w_shift_in;
  logic [BCW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic r_ack, w_ack_nxt;
  logic r_start_det, w_start_nxt;
  logic r_stop_det, w_stop_nxt;
  logic r_dv, w_dv_nxt;
  logic r_av, w_av_nxt;
  logic r_bus_busy, w_busy_nxt;
  logic r_timeout, w_to_nxt;

  // Raw line synchronisers, idle-high after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign w_line_s = {r_sda_sync[SYNC_STAGES-1], r_scl_sync[SYNC_STAGES-1]};

  // Per-line glitch filter (index 0 = SCL, 1 = SDA) and previous-value registers for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_f <= 2'b11;
      r_line_p <= 2'b11;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      r_line_p <= r_line_f;
      for (int i = 0; i < 2; i++) begin
        if (w_line_s[i] == r_line_f[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FILT_LAST) begin
          r_line_f[i] <= ~r_line_f[i];
          r_fcnt[i]   <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FCW'(1);
        end
      end
    end
  end

  assign w_scl_f = r_line_f[0];
  assign w_sda_f = r_line_f[1];
  assign w_scl_p = r_line_p[0];
  assign w_sda_p = r_line_p[1];

  // Requiring SCL high on both samples suppresses START/STOP when both lines move together.
  assign w_start = w_scl_p & w_scl_f & w_sda_p & ~w_sda_f;
  assign w_stop  = w_scl_p & w_scl_f & ~w_sda_p & w_sda_f;
  assign w_rise  = ~w_scl_p & w_scl_f;

`ifdef I2C_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYC - 1);
  logic [TCW-1:0] r_to_cnt;
  logic           w_to_hit;

  assign w_to_hit = r_bus_busy & ~w_scl_f & (r_to_cnt == TO_LAST);
  assign w_to_evt = w_to_hit & ~w_stop;

  // SCL-low duration counter while the bus is owned.
  always_ff @(posedge clk) begin
    if (rst || !r_bus_busy || w_scl_f || w_to_hit) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TCW'(1);
    end
  end
`else
  assign w_to_evt = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: STOP/timeout, then START, then SCL rise.
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop || w_to_evt) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = ST_DATA;
    end else begin
      case (r_state)
        ST_DATA: w_state_nxt = (w_rise && (r_bit_cnt == BIT_LAST)) ? ST_ACK : ST_DATA;
        ST_ACK:  w_state_nxt = w_rise ? ST_DATA : ST_ACK;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_shift_in = {r_shift, w_sda_f};

  // Next values of the datapath and output registers, with the same event priority as the FSM.
  always_comb begin
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_data_nxt    = r_data;
    w_ack_nxt     = r_ack;
    w_busy_nxt    = r_bus_busy;
    w_start_nxt   = 1'b0;
    w_stop_nxt    = 1'b0;
    w_dv_nxt      = 1'b0;
    w_av_nxt      = 1'b0;
    w_to_nxt      = w_to_evt;
    if (w_stop || w_to_evt) begin
      w_stop_nxt    = w_stop;
      w_busy_nxt    = 1'b0;
      w_shift_nxt   = '0;
      w_bit_cnt_nxt = '0;
    end else if (w_start) begin
      w_start_nxt   = 1'b1;
      w_busy_nxt    = 1'b1;
      w_shift_nxt   = '0;
      w_bit_cnt_nxt = '0;
    end else if (w_rise) begin
      case (r_state)
        ST_DATA: begin
          w_shift_nxt   = w_shift_in[DATA_W-2:0];
          w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
          w_dv_nxt      = (r_bit_cnt == BIT_LAST);
          w_data_nxt    = (r_bit_cnt == BIT_LAST) ? w_shift_in : r_data;
        end
        ST_ACK: begin
          w_ack_nxt     = w_sda_f;
          w_av_nxt      = 1'b1;
          w_bit_cnt_nxt = '0;
        end
        default: w_bit_cnt_nxt = r_bit_cnt;
      endcase
    end else begin
      w_shift_nxt = r_shift;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_data      <= '0;
      r_ack       <= 1'b1;
      r_bus_busy  <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_dv        <= 1'b0;
      r_av        <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_data      <= w_data_nxt;
      r_ack       <= w_ack_nxt;
      r_bus_busy  <= w_busy_nxt;
      r_start_det <= w_start_nxt;
      r_stop_det  <= w_stop_nxt;
      r_dv        <= w_dv_nxt;
      r_av        <= w_av_nxt;
      r_timeout   <= w_to_nxt;
    end
  end

  assign start_det  = r_start_det;
  assign stop_det   = r_stop_det;
  assign bus_busy   = r_bus_busy;
  assign data_out   = r_data;
  assign data_valid = r_dv;
  assign ack_bit    = r_ack;
  assign ack_valid  = r_av;
  assign timeout    = r_timeout;

endmodule
